pc_sequencer: RTL and testbench

//   Multi-cycle instruction sequencer that owns the architectural PC and steps each instruction

---
 rtl/pc_sequencer.sv | 131 +++++++++++++
 tb/tb_pc_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Multi-cycle PC sequencer: FETCH -> WAIT_RSP -> EXEC -> UPDATE, retire count.
// Optional PC_MISALIGN_TRAP_EN: misaligned next PC halts instead of retiring.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          CNT_W    = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             ifu_req_valid,
  input  logic             ifu_req_ready,
  output logic [31:0]      ifu_addr,
  input  logic             ifu_rsp_valid,
  input  logic [31:0]      ifu_rsp_inst,
  output logic             exe_start,
  output logic [31:0]      inst,
  input  logic             exe_done,
  input  logic             pc_src_a,
  input  logic             pc_src_b,
  input  logic [31:0]      imm,
  input  logic [31:0]      rs1,
  input  logic             halt,
  output logic [31:0]      pc,
  output logic             commit,
  output logic             halted,
  output logic [CNT_W-1:0] instret,
  output logic             misalign_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_EXEC,
    S_UPDATE,
    S_HALT
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_pc;
  logic [31:0]      r_inst;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_npc;
  logic             r_halt;
  logic             r_first;
  logic [31:0]      w_op_a;
  logic [31:0]      w_op_b;
  logic [31:0]      w_sum;
  logic [31:0]      w_npc;
  logic [31:0]      w_pc_upd;
  logic             w_bad;

  assign w_op_a = pc_src_a ? imm : 32'd4;
  assign w_op_b = pc_src_b ? rs1 : r_pc;
  assign w_sum  = w_op_a + w_op_b;
  // jalr target drops bit 0
  assign w_npc  = {w_sum[31:1], w_sum[0] & ~pc_src_b};

`ifdef PC_MISALIGN_TRAP_EN
  logic r_mis;

  assign w_bad    = (r_state == S_UPDATE) && (r_npc[1:0] != 2'b00);
  assign w_pc_upd = r_npc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mis <= 1'b0;
    end else if (w_bad) begin
      r_mis <= 1'b1;
    end
  end

  assign misalign_err = r_mis;
`else
  assign w_bad        = 1'b0;
  assign w_pc_upd     = {r_npc[31:2], 2'b00};
  assign misalign_err = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH:  if (ifu_req_ready) w_next = S_WAIT;
      S_WAIT:   if (ifu_rsp_valid) w_next = S_EXEC;
      S_EXEC:   if (exe_done) w_next = S_UPDATE;
      S_UPDATE: w_next = (w_bad || r_halt) ? S_HALT : S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_inst  <= 32'd0;
      r_cnt   <= '0;
      r_npc   <= 32'd0;
      r_halt  <= 1'b0;
      r_first <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_WAIT && ifu_rsp_valid) begin
        r_inst  <= ifu_rsp_inst;
        r_first <= 1'b1;
      end
      if (r_state == S_EXEC) begin
        r_first <= 1'b0;
        if (exe_done) begin
          r_npc  <= w_npc;
          r_halt <= halt;
        end
      end
      if (r_state == S_UPDATE && !w_bad) begin
        r_pc  <= w_pc_upd;
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign ifu_req_valid = (r_state == S_FETCH);
  assign ifu_addr      = r_pc;
  assign exe_start     = (r_state == S_EXEC) && r_first;
  assign inst          = r_inst;
  assign pc            = r_pc;
  assign commit        = (r_state == S_UPDATE) && !w_bad;
  assign halted        = (r_state == S_HALT);
  assign instret       = r_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised bench for pc_sequencer against a per-instruction PC model.
// The model honours PC_MISALIGN_TRAP_EN when the macro is defined.
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ifu_req_valid;
  logic        ifu_req_ready = 1'b0;
  logic [31:0] ifu_addr;
  logic        ifu_rsp_valid = 1'b0;
  logic [31:0] ifu_rsp_inst = 32'd0;
  logic        exe_start;
  logic [31:0] inst;
  logic        exe_done = 1'b0;
  logic        pc_src_a = 1'b0;
  logic        pc_src_b = 1'b0;
  logic [31:0] imm = 32'd0;
  logic [31:0] rs1 = 32'd0;
  logic        halt = 1'b0;
  logic [31:0] pc;
  logic        commit;
  logic        halted;
  logic [63:0] instret;
  logic        misalign_err;

  int          n_tests = 0;
  int          n_fail = 0;

  logic [31:0] m_pc;
  logic [63:0] m_cnt;
  logic        m_halted;
  logic        m_mis;

  pc_sequencer #(.RESET_PC(RST_PC), .CNT_W(64)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_addr      (ifu_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_inst  (ifu_rsp_inst),
    .exe_start     (exe_start),
    .inst          (inst),
    .exe_done      (exe_done),
    .pc_src_a      (pc_src_a),
    .pc_src_b      (pc_src_b),
    .imm           (imm),
    .rs1           (rs1),
    .halt          (halt),
    .pc            (pc),
    .commit        (commit),
    .halted        (halted),
    .instret       (instret),
    .misalign_err  (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    exe_done      = 1'b0;
    halt          = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("rst_req_valid", 64'(ifu_req_valid), 64'd0);
    chk("rst_exe_start", 64'(exe_start), 64'd0);
    chk("rst_commit", 64'(commit), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_misalign", 64'(misalign_err), 64'd0);
    chk("rst_pc", 64'(pc), 64'(RST_PC));
    chk("rst_inst", 64'(inst), 64'd0);
    chk("rst_instret", instret, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("idle_req_valid", 64'(ifu_req_valid), 64'd0);
    @(negedge clk);
    m_pc     = RST_PC;
    m_cnt    = 64'd0;
    m_halted = 1'b0;
    m_mis    = 1'b0;
  endtask

  task automatic halt_idle();
    for (int i = 0; i < 5; i++) begin
      ifu_req_ready = 1'b1;
      ifu_rsp_valid = 1'b1;
      exe_done      = 1'b1;
      pc_src_a      = 1'b1;
      imm           = $urandom;
      @(negedge clk);
      chk("halt_req_valid", 64'(ifu_req_valid), 64'd0);
      chk("halt_level", 64'(halted), 64'd1);
      chk("halt_commit", 64'(commit), 64'd0);
      chk("halt_pc", 64'(pc), 64'(m_pc));
      chk("halt_instret", instret, m_cnt);
    end
    do_reset();
  endtask

  task automatic run_inst(input int rdy_d, input int rsp_d, input int done_d,
                          input bit a, input bit b,
                          input logic [31:0] imm_v, input logic [31:0] rs1_v,
                          input bit hlt, input bit spur, input bit rst_exec);
    int          cyc;
    logic [31:0] word;
    logic [31:0] sum;
    bit          trap;
    cyc  = 0;
    word = $urandom;
    chk("fetch_valid", 64'(ifu_req_valid), 64'd1);
    chk("fetch_addr", 64'(ifu_addr), 64'(m_pc));
    for (int i = 0; i < rdy_d; i++) begin
      ifu_req_ready = 1'b0;
      ifu_rsp_valid = spur;
      ifu_rsp_inst  = ~word;
      @(negedge clk);
      cyc++;
      chk("stall_valid", 64'(ifu_req_valid), 64'd1);
      chk("stall_addr", 64'(ifu_addr), 64'(m_pc));
    end
    ifu_rsp_valid = 1'b0;
    ifu_req_ready = 1'b1;
    @(negedge clk);
    cyc++;
    ifu_req_ready = 1'b0;
    chk("wait_valid", 64'(ifu_req_valid), 64'd0);
    for (int i = 0; i < rsp_d; i++) begin
      @(negedge clk);
      cyc++;
      chk("wait_start", 64'(exe_start), 64'd0);
    end
    ifu_rsp_valid = 1'b1;
    ifu_rsp_inst  = word;
    @(negedge clk);
    cyc++;
    ifu_rsp_valid = 1'b0;
    chk("exe_start", 64'(exe_start), 64'd1);
    chk("inst", 64'(inst), 64'(word));
    if (rst_exec) begin
      do_reset();
      return;
    end
    for (int i = 0; i < done_d; i++) begin
      ifu_rsp_valid = spur;
      ifu_rsp_inst  = ~word;
      halt          = 1'b1;
      @(negedge clk);
      cyc++;
      chk("start_pulse", 64'(exe_start), 64'd0);
      chk("inst_hold", 64'(inst), 64'(word));
    end
    ifu_rsp_valid = 1'b0;
    exe_done      = 1'b1;
    pc_src_a      = a;
    pc_src_b      = b;
    imm           = imm_v;
    rs1           = rs1_v;
    halt          = hlt;
    @(negedge clk);
    cyc++;
    exe_done = 1'b0;
    halt     = 1'b0;
    imm      = $urandom;
    rs1      = $urandom;
    sum = (a ? imm_v : 32'd4) + (b ? rs1_v : m_pc);
    if (b) sum = sum & ~32'd1;
`ifdef PC_MISALIGN_TRAP_EN
    trap = (sum % 4) != 0;
`else
    trap = 1'b0;
    sum  = sum - (sum % 4);
`endif
    chk("commit", 64'(commit), 64'(!trap));
    chk("pc_before", 64'(pc), 64'(m_pc));
    if (!trap) begin
      m_pc  = sum;
      m_cnt = m_cnt + 64'd1;
    end else begin
      m_mis = 1'b1;
    end
    m_halted = hlt || trap;
    @(negedge clk);
    cyc++;
    chk("commit_pulse", 64'(commit), 64'd0);
    chk("pc_after", 64'(pc), 64'(m_pc));
    chk("instret", instret, m_cnt);
    chk("halted", 64'(halted), 64'(m_halted));
    chk("next_valid", 64'(ifu_req_valid), 64'(!m_halted));
    chk("misalign", 64'(misalign_err), 64'(m_mis));
    if (rdy_d == 0 && rsp_d == 0 && done_d == 0)
      chk("min_cycles", 64'(cyc), 64'd4);
  endtask

  initial begin
    #2;
    do_reset();
    run_inst(0, 0, 0, 0, 0, 32'd0, 32'd0, 0, 0, 0);
    run_inst(0, 0, 0, 1, 1, 32'h10, RST_PC, 0, 0, 0);
    run_inst(0, 0, 0, 1, 0, 32'hFFFF_FFF0, 32'd0, 0, 0, 0);
    run_inst(0, 1, 2, 1, 1, 32'h2, 32'h8000_0101, 0, 0, 0);
    if (m_halted) halt_idle();
    run_inst(5, 0, 0, 0, 0, 32'd0, 32'd0, 0, 1, 0);
    run_inst(0, 0, 0, 1, 1, 32'h20, RST_PC, 0, 0, 0);
    run_inst(0, 0, 0, 0, 0, 32'd0, 32'd0, 1, 0, 0);
    halt_idle();
    run_inst(1, 0, 0, 0, 0, 32'd0, 32'd0, 0, 0, 1);
    run_inst(0, 0, 0, 0, 0, 32'd0, 32'd0, 0, 0, 0);
    for (int k = 0; k < 150; k++) begin
      run_inst($urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), 1'($urandom), 1'($urandom),
               $urandom, $urandom, $urandom_range(0, 15) == 0,
               1'($urandom), $urandom_range(0, 31) == 0);
      if (m_halted) halt_idle();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
